bcd2bin_seq: RTL and testbench
==============================

# bcd2bin_seq

Sequential BCD-to-binary converter: the inverse of the design's binary-to-BCD path. Accepts a three-digit BCD value (hundreds, tens, ones) from the operand-entry logic and produces an unsigned binary word for the ALU operand path. It uses iterative reverse double-dabble (shift right, then subtract 3 from any digit ≥ 8) over a start/busy/done handshake, and flags invalid digits and results that do not fit the output width.

## Interface
Parameters:
- OUT_W, 8: output binary width; legal range 8–10. Conversion width is fixed at 10 bits, which covers 999.

Ports:
- clk  in  1  system clock (50 MHz)
- ar  in  1  reset, synchronous, active-high
- start  in  1  request conversion; sampled only in IDLE
- hundreds  in  4  BCD hundreds digit
- tens  in  4  BCD tens digit
- ones  in  4  BCD ones digit
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse: result, ovf and err are valid
- bin_out  out  OUT_W  converted value; holds until the next done
- ovf  out  1  value > 2^OUT_W − 1; bin_out saturated to all-ones
- err  out  1  an input digit was > 9; bin_out = 0

## Operation
- States:
  - IDLE: waits for start.
  - CONV: runs the conversion iterations.
  - FIN: registers the outputs.
- IDLE:
  - If start=1, latch the digits into a 22-bit shift register {bcd[11:0], bin[9:0]} with bin cleared.
  - Clear iteration counter cnt (4 bits).
  - If any digit > 9, go to FIN with the error flag set internally; otherwise go to CONV.
- CONV, each cycle:
  - Shift the register right by 1. The LSB of bcd enters the MSB of bin.
  - After the shift, for each of the 3 digit nibbles: if nibble ≥ 8, subtract 3.
  - Increment cnt. After the 10th iteration (cnt = 9 at the edge), go to FIN.
- FIN, for one cycle, then return to IDLE:
  - Error case: err=1, ovf=0, bin_out=0.
  - Otherwise, if bin[9:0] > 2^OUT_W − 1: ovf=1, bin_out=all-ones.
  - Otherwise: bin_out=bin[OUT_W−1:0], ovf=0, err=0.
  - done=1.
- Arithmetic: all digit adjustments are unsigned 4-bit. After 10 iterations the bcd field is guaranteed zero for valid input; a non-zero residue is a design error and must be checked by an assertion in the bench.
- start while busy (CONV or FIN) is ignored; it is not queued.
- Input digits may change after acceptance without affecting the result.
- start held high continuously: a new conversion is accepted in the IDLE cycle following FIN.

## Timing
- Reset (ar=1 at a rising edge): state=IDLE, cnt=0, busy=0, done=0, bin_out=0, ovf=0, err=0.
- Reset mid-conversion aborts: no done pulse, outputs return to reset values on the same edge.
- Let edge k be the edge at which start is accepted.
- Valid digits:
  - busy=1 from after edge k.
  - CONV occupies edges k+1..k+10; FIN at edge k+11.
  - done, bin_out, ovf and err update at edge k+11; busy falls at edge k+11.
  - Total latency is 11 cycles.
- Invalid digits:
  - FIN at edge k+1; done and err=1 appear after edge k+1.
  - busy is high for exactly one cycle.
- done is high for exactly one cycle.
- bin_out, ovf and err are held stable until the next FIN or reset.
- Throughput: one conversion per 12 cycles (valid input).

## Structure
- Shared package pr4_pkg contains:
  - state enum (IDLE, CONV, FIN)
  - CONV_W=10
  - N_ITER=10
  - BCD_DIGITS=3
- Sub-module bcd_digit_adj: combinational 4-bit nibble adjust (≥8 → −3), instantiated 3 times. All sequencing stays in bcd2bin_seq.

## Test plan
- Valid conversion: hundreds=1, tens=2, ones=3, start pulse at edge k → done after edge k+11, bin_out=8'h7B, ovf=0, err=0, busy high for exactly 11 cycles.
- Largest in-range value: 2/5/5 → bin_out=8'hFF, ovf=0. Then 2/5/6 → bin_out=8'hFF, ovf=1.
- 999 with OUT_W=10 → bin_out=10'h3E7, ovf=0. 999 with OUT_W=8 → bin_out=8'hFF, ovf=1.
- Invalid digit: tens=4'hA → done after edge k+1, err=1, bin_out=0, busy high for one cycle.
- start re-asserted during CONV, digits changed to 9/9/9 → ignored, original result delivered, exactly one done pulse. Conversions 0/0/0 then 0/0/1 back to back → 0 then 1.
- ar=1 at edge k+5 of a conversion → all outputs 0 on that edge, no done pulse. Next start converts normally.

Source files
------------

// File: rtl/pr4_pkg.sv
// Shared types and sizing for the sequential BCD-to-binary converter.
package pr4_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int CONV_W     = 10;
  localparam int N_ITER     = 10;
  localparam int BCD_DIGITS = 3;
  localparam int SR_W       = 4 * BCD_DIGITS + CONV_W;

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble nibble correction: digits >= 8 after a right shift lose 3.
// Purely combinational, no handshake.
module bcd_digit_adj (
  input  logic [3:0] nib,
  output logic [3:0] adj
);

  assign adj = (nib >= 4'd8) ? (nib - 4'd3) : nib;

endmodule

// File: rtl/bcd2bin_seq.sv
// Iterative three-digit BCD to binary converter, start/busy/done handshake.
// 11 cycles from accepted start to done (1 for bad digits); start while busy is dropped.
module bcd2bin_seq
  import pr4_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             ar,
  input  logic             start,
  input  logic [3:0]       hundreds,
  input  logic [3:0]       tens,
  input  logic [3:0]       ones,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] bin_out,
  output logic             ovf,
  output logic             err
);

  localparam logic [CONV_W-1:0] MAX_OUT = CONV_W'((1 << OUT_W) - 1);

  state_t          state;
  logic [3:0]      cnt;
  logic [SR_W-1:0] sr;
  logic [SR_W-1:0] sr_shift;
  logic [SR_W-1:0] sr_next;
  logic            bad;
  logic            digit_bad;

  assign digit_bad = (hundreds > 4'd9) || (tens > 4'd9) || (ones > 4'd9);

  // Register layout is {hundreds, tens, ones, bin}; the binary field fills from its MSB.
  assign sr_shift               = sr >> 1;
  assign sr_next[CONV_W-1:0]    = sr_shift[CONV_W-1:0];

  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .nib (sr_shift[CONV_W + 4*i +: 4]),
      .adj (sr_next[CONV_W + 4*i +: 4])
    );
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (ar) begin
      state   <= IDLE;
      cnt     <= '0;
      sr      <= '0;
      bad     <= 1'b0;
      done    <= 1'b0;
      bin_out <= '0;
      ovf     <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (start) begin
            sr    <= {hundreds, tens, ones, {CONV_W{1'b0}}};
            bad   <= digit_bad;
            state <= digit_bad ? FIN : CONV;
          end
        end
        CONV: begin
          sr  <= sr_next;
          cnt <= cnt + 4'd1;
          if (cnt == 4'(N_ITER - 1)) state <= FIN;
        end
        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
          if (bad) begin
            err     <= 1'b1;
            ovf     <= 1'b0;
            bin_out <= '0;
          end else if (sr[CONV_W-1:0] > MAX_OUT) begin
            err     <= 1'b0;
            ovf     <= 1'b1;
            bin_out <= '1;
          end else begin
            err     <= 1'b0;
            ovf     <= 1'b0;
            bin_out <= sr[OUT_W-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed bench for bcd2bin_seq: one 8-bit and one 10-bit instance share stimulus.
module tb_bcd2bin_seq;
  import pr4_pkg::*;

  logic       clk = 1'b0;
  logic       ar = 1'b1;
  logic       start = 1'b0;
  logic [3:0] hundreds = 4'd0, tens = 4'd0, ones = 4'd0;
  logic       busy8, done8, ovf8, err8;
  logic [7:0] bin8;
  logic       busy10, done10, ovf10, err10;
  logic [9:0] bin10;

  int checks = 0;
  int failures = 0;

  always #10 clk = ~clk;

  bcd2bin_seq #(.OUT_W(8)) dut8 (
    .clk(clk), .ar(ar), .start(start), .hundreds(hundreds), .tens(tens), .ones(ones),
    .busy(busy8), .done(done8), .bin_out(bin8), .ovf(ovf8), .err(err8)
  );

  bcd2bin_seq #(.OUT_W(10)) dut10 (
    .clk(clk), .ar(ar), .start(start), .hundreds(hundreds), .tens(tens), .ones(ones),
    .busy(busy10), .done(done10), .bin_out(bin10), .ovf(ovf10), .err(err10)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // A valid conversion must leave no BCD residue when it reaches FIN.
  always @(negedge clk) begin
    if (!ar && dut8.state == FIN && !dut8.bad) begin
      check("bcd_residue", 32'(dut8.sr[21:10]), 32'h0);
      bcd_residue_zero: assert (dut8.sr[21:10] == 12'h0);
    end
  end

  typedef struct {
    logic [3:0]  h, t, o;
    logic [31:0] b8;
    logic        o8;
    logic [31:0] b10;
    logic        o10;
    logic        e;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic issue(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    @(negedge clk);
    hundreds = h; tens = t; ones = o; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge after the accepting edge; lat = edges until done seen.
  task automatic wait_done(output int lat, output int bcyc);
    lat = 0; bcyc = 0;
    while (!done8 && lat < 40) begin
      if (busy8) bcyc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_case(input string nm, input vec_t v);
    int lat, bcyc;
    issue(v.h, v.t, v.o);
    wait_done(lat, bcyc);
    check({nm, "_lat"}, 32'(lat), 32'(v.lat));
    check({nm, "_busy"}, 32'(bcyc), 32'(v.lat));
    check({nm, "_bin8"}, 32'(bin8), v.b8);
    check({nm, "_ovf8"}, 32'(ovf8), 32'(v.o8));
    check({nm, "_err8"}, 32'(err8), 32'(v.e));
    check({nm, "_done10"}, 32'(done10), 32'h1);
    check({nm, "_bin10"}, 32'(bin10), v.b10);
    check({nm, "_ovf10"}, 32'(ovf10), 32'(v.o10));
    check({nm, "_err10"}, 32'(err10), 32'(v.e));
    @(negedge clk);
    check({nm, "_done_drop"}, 32'(done8), 32'h0);
    check({nm, "_bin_hold"}, 32'(bin8), v.b8);
  endtask

  initial begin
    int lat, bcyc, ndone;
    logic [31:0] got;

    vecs[0] = '{4'd1, 4'd2, 4'd3, 32'h7B, 1'b0, 32'h07B, 1'b0, 1'b0, 11};
    vecs[1] = '{4'd2, 4'd5, 4'd5, 32'hFF, 1'b0, 32'h0FF, 1'b0, 1'b0, 11};
    vecs[2] = '{4'd2, 4'd5, 4'd6, 32'hFF, 1'b1, 32'h100, 1'b0, 1'b0, 11};
    vecs[3] = '{4'd9, 4'd9, 4'd9, 32'hFF, 1'b1, 32'h3E7, 1'b0, 1'b0, 11};
    vecs[4] = '{4'd5, 4'd0, 4'd0, 32'hFF, 1'b1, 32'h1F4, 1'b0, 1'b0, 11};
    vecs[5] = '{4'd1, 4'hA, 4'd3, 32'h00, 1'b0, 32'h000, 1'b0, 1'b1, 1};
    vecs[6] = '{4'hF, 4'd0, 4'd0, 32'h00, 1'b0, 32'h000, 1'b0, 1'b1, 1};
    vecs[7] = '{4'd0, 4'd4, 4'd2, 32'h2A, 1'b0, 32'h02A, 1'b0, 1'b0, 11};

    repeat (3) @(negedge clk);
    ar = 1'b0;
    check("rst_busy", 32'(busy8), 32'h0);
    check("rst_done", 32'(done8), 32'h0);
    check("rst_bin", 32'(bin8), 32'h0);
    check("rst_ovf", 32'(ovf8), 32'h0);
    check("rst_err", 32'(err8), 32'h0);

    for (int i = 0; i < 8; i++) run_case($sformatf("v%0d", i), vecs[i]);

    // start held high: 0/0/0 accepted, then 0/0/1 accepted right after FIN.
    @(negedge clk);
    hundreds = 4'd0; tens = 4'd0; ones = 4'd0; start = 1'b1;
    @(negedge clk);
    ones = 4'd1;
    wait_done(lat, bcyc);
    check("b2b0_lat", 32'(lat), 32'd11);
    check("b2b0_bin", 32'(bin8), 32'h0);
    @(negedge clk);
    wait_done(lat, bcyc);
    start = 1'b0;
    check("b2b1_lat", 32'(lat), 32'd11);
    check("b2b1_bin", 32'(bin8), 32'h1);

    // start during CONV with new digits is ignored.
    issue(4'd1, 4'd2, 4'd3);
    ndone = 0; got = 32'hDEAD;
    for (int n = 0; n < 25; n++) begin
      if (n == 2) begin
        hundreds = 4'd9; tens = 4'd9; ones = 4'd9; start = 1'b1;
      end
      if (n == 5) start = 1'b0;
      if (done8) begin
        ndone++;
        got = 32'(bin8);
      end
      @(negedge clk);
    end
    check("ign_ndone", 32'(ndone), 32'd1);
    check("ign_bin", got, 32'h7B);

    // Reset at edge k+5 aborts the conversion.
    run_case("pre_rst", vecs[3]);
    issue(4'd1, 4'd2, 4'd3);
    repeat (4) @(negedge clk);
    ar = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy8), 32'h0);
    check("abort_busy10", 32'(busy10), 32'h0);
    check("abort_done", 32'(done8), 32'h0);
    check("abort_bin", 32'(bin8), 32'h0);
    check("abort_ovf", 32'(ovf8), 32'h0);
    check("abort_err", 32'(err8), 32'h0);
    check("abort_bin10", 32'(bin10), 32'h0);
    ar = 1'b0;
    ndone = 0;
    for (int n = 0; n < 20; n++) begin
      if (done8) ndone++;
      @(negedge clk);
    end
    check("abort_nodone", 32'(ndone), 32'd0);
    run_case("post_rst", vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
